// File: rtl/usb3_endp_mux.sv
// Endpoint buffer router between the USB3 link layer and NUM_EP endpoint buffers.
// Adds per-endpoint halt/sequence state and a commit/arm handshake FSM with timeout.
module usb3_endp_mux #(
  parameter int          NUM_EP      = 4,
  parameter int          ADDR_W      = 9,
  parameter int          DATA_W      = 32,
  parameter int          LEN_W       = 11,
  parameter logic [15:0] EP_IN_MASK  = 16'h0005,
  parameter logic [15:0] EP_OUT_MASK = 16'h0003,
  parameter logic [31:0] EP_MODES    = 32'h0000_00A0,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                       local_clk,
  input  logic                       reset,
  input  logic [3:0]                 sel_endp,
  input  logic [ADDR_W-1:0]          buf_in_addr,
  input  logic [DATA_W-1:0]          buf_in_data,
  input  logic                       buf_in_wren,
  input  logic                       buf_in_commit,
  input  logic [LEN_W-1:0]           buf_in_commit_len,
  output logic                       buf_in_ready,
  output logic                       buf_in_commit_ack,
  input  logic [ADDR_W-1:0]          buf_out_addr,
  input  logic                       buf_out_arm,
  output logic [DATA_W-1:0]          buf_out_q,
  output logic [LEN_W-1:0]           buf_out_len,
  output logic                       buf_out_hasdata,
  output logic                       buf_out_arm_ack,
  output logic [1:0]                 endp_mode,
  output logic [4:0]                 endp_seq,
  output logic                       endp_halted,
  output logic [NUM_EP*ADDR_W-1:0]   ep_in_addr,
  output logic [NUM_EP*DATA_W-1:0]   ep_in_data,
  output logic [NUM_EP-1:0]          ep_in_wren,
  output logic [NUM_EP-1:0]          ep_in_commit,
  output logic [NUM_EP*LEN_W-1:0]    ep_in_commit_len,
  input  logic [NUM_EP-1:0]          ep_in_ready,
  input  logic [NUM_EP-1:0]          ep_in_commit_ack,
  output logic [NUM_EP*ADDR_W-1:0]   ep_out_addr,
  output logic [NUM_EP-1:0]          ep_out_arm,
  input  logic [NUM_EP*DATA_W-1:0]   ep_out_q,
  input  logic [NUM_EP*LEN_W-1:0]    ep_out_len,
  input  logic [NUM_EP-1:0]          ep_out_hasdata,
  input  logic [NUM_EP-1:0]          ep_out_arm_ack,
  input  logic [NUM_EP-1:0]          halt_set,
  input  logic [NUM_EP-1:0]          halt_clr,
  input  logic [NUM_EP-1:0]          seq_clr,
  output logic                       err_undefined,
  output logic                       err_timeout
);

  localparam int             CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]     NUM_EP_L = 5'(NUM_EP);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_OUT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               act_ep_q, act_ep_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_EP-1:0]        halt_q, halt_d;
  logic [NUM_EP-1:0][4:0]   seq_q, seq_d;
  logic                     err_undef_q, err_undef_d;

  logic [3:0] eff_ep;
  logic       eff_valid;
  logic       in_ok, out_ok, halted_eff, ack_in, ack_out;
  logic       commit_go, arm_go, hs_done;

  // Routing is purely combinational so IDLE selection has zero latency;
  // reset forces everything quiet, including a pending ack.
  assign eff_ep    = (state_q == ST_IDLE) ? sel_endp : act_ep_q;
  assign eff_valid = !reset && ({1'b0, eff_ep} < NUM_EP_L);

  always_comb begin
    in_ok           = 1'b0;
    out_ok          = 1'b0;
    halted_eff      = 1'b0;
    ack_in          = 1'b0;
    ack_out         = 1'b0;
    buf_in_ready    = 1'b0;
    buf_out_q       = '0;
    buf_out_len     = '0;
    buf_out_hasdata = 1'b0;
    endp_mode       = 2'd0;
    endp_seq        = 5'd0;
    endp_halted     = 1'b0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (eff_valid && eff_ep == 4'(n)) begin
        in_ok           = EP_IN_MASK[n];
        out_ok          = EP_OUT_MASK[n];
        halted_eff      = halt_q[n];
        ack_in          = ep_in_commit_ack[n];
        ack_out         = ep_out_arm_ack[n];
        buf_in_ready    = ep_in_ready[n] & ~halt_q[n];
        buf_out_q       = ep_out_q[n*DATA_W +: DATA_W];
        buf_out_len     = ep_out_len[n*LEN_W +: LEN_W];
        buf_out_hasdata = ep_out_hasdata[n] & ~halt_q[n];
        endp_mode       = EP_MODES[2*n +: 2];
        endp_seq        = seq_q[n];
        endp_halted     = halt_q[n];
      end
    end
  end

  // A simultaneous commit suppresses the arm entirely, including its error check.
  assign commit_go = (state_q == ST_IDLE) && buf_in_commit && in_ok && !halted_eff;
  assign arm_go    = (state_q == ST_IDLE) && buf_out_arm && !buf_in_commit && out_ok && !halted_eff;

  assign buf_in_commit_ack = (state_q == ST_WAIT_IN) && ack_in;
  assign buf_out_arm_ack   = (state_q == ST_WAIT_OUT) && ack_out;
  assign err_undefined     = err_undef_q;

  always_comb begin
    ep_in_addr       = '0;
    ep_in_data       = '0;
    ep_in_wren       = '0;
    ep_in_commit     = '0;
    ep_in_commit_len = '0;
    ep_out_addr      = '0;
    ep_out_arm       = '0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (eff_valid && eff_ep == 4'(n)) begin
        if (EP_IN_MASK[n]) begin
          ep_in_addr[n*ADDR_W +: ADDR_W] = buf_in_addr;
          ep_in_data[n*DATA_W +: DATA_W] = buf_in_data;
          ep_in_wren[n]                  = buf_in_wren;
        end
        ep_in_commit[n] = commit_go;
        if (commit_go) begin
          ep_in_commit_len[n*LEN_W +: LEN_W] = buf_in_commit_len;
        end else if (state_q == ST_WAIT_IN) begin
          ep_in_commit_len[n*LEN_W +: LEN_W] = len_q;
        end
        if (EP_OUT_MASK[n]) begin
          ep_out_addr[n*ADDR_W +: ADDR_W] = buf_out_addr;
        end
        ep_out_arm[n] = arm_go;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    act_ep_d    = act_ep_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_timeout = 1'b0;
    hs_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_go) begin
          state_d  = ST_WAIT_IN;
          act_ep_d = sel_endp;
          len_d    = buf_in_commit_len;
          cnt_d    = '0;
        end else if (arm_go) begin
          state_d  = ST_WAIT_OUT;
          act_ep_d = sel_endp;
          cnt_d    = '0;
        end
      end
      ST_WAIT_IN, ST_WAIT_OUT: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if ((state_q == ST_WAIT_IN) ? ack_in : ack_out) begin
          hs_done = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout = !reset;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    halt_d = halt_q;
    seq_d  = seq_q;
    for (int n = 0; n < NUM_EP; n++) begin
      halt_d[n] = halt_set[n] | (halt_q[n] & ~halt_clr[n]);
      if (seq_clr[n]) begin
        seq_d[n] = 5'd0;
      end else if (hs_done && act_ep_q == 4'(n)) begin
        seq_d[n] = seq_q[n] + 5'd1;
      end
    end
    err_undef_d = (buf_in_wren && !in_ok)
                || ((state_q == ST_IDLE) && buf_in_commit && !in_ok)
                || ((state_q == ST_IDLE) && buf_out_arm && !buf_in_commit && !out_ok);
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      act_ep_q    <= 4'd0;
      len_q       <= '0;
      cnt_q       <= '0;
      halt_q      <= '0;
      seq_q       <= '0;
      err_undef_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_ep_q    <= act_ep_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      halt_q      <= halt_d;
      seq_q       <= seq_d;
      err_undef_q <= err_undef_d;
    end
  end

endmodule

// File: tb/tb_usb3_endp_mux.sv
// Bench for usb3_endp_mux: directed plan steps followed by random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_usb3_endp_mux;
  localparam int NUM_EP = 4, ADDR_W = 9, DATA_W = 32, LEN_W = 11, TC = 8;

  logic                      local_clk = 1'b0;
  logic                      reset;
  logic [3:0]                sel_endp;
  logic [ADDR_W-1:0]         buf_in_addr, buf_out_addr;
  logic [DATA_W-1:0]         buf_in_data;
  logic                      buf_in_wren, buf_in_commit, buf_out_arm;
  logic [LEN_W-1:0]          buf_in_commit_len;
  logic                      buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_arm_ack;
  logic [DATA_W-1:0]         buf_out_q;
  logic [LEN_W-1:0]          buf_out_len;
  logic [1:0]                endp_mode;
  logic [4:0]                endp_seq;
  logic                      endp_halted, err_undefined, err_timeout;
  logic [NUM_EP*ADDR_W-1:0]  ep_in_addr, ep_out_addr;
  logic [NUM_EP*DATA_W-1:0]  ep_in_data, ep_out_q;
  logic [NUM_EP*LEN_W-1:0]   ep_in_commit_len, ep_out_len;
  logic [NUM_EP-1:0]         ep_in_wren, ep_in_commit, ep_in_ready, ep_in_commit_ack;
  logic [NUM_EP-1:0]         ep_out_arm, ep_out_hasdata, ep_out_arm_ack;
  logic [NUM_EP-1:0]         halt_set, halt_clr, seq_clr;

  usb3_endp_mux #(
    .NUM_EP(NUM_EP), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .EP_IN_MASK(16'h0005), .EP_OUT_MASK(16'h0003), .EP_MODES(32'h0000_00A0),
    .TIMEOUT_CYC(TC)
  ) dut (
    .local_clk(local_clk), .reset(reset), .sel_endp(sel_endp),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
    .buf_in_ready(buf_in_ready), .buf_in_commit_ack(buf_in_commit_ack),
    .buf_out_addr(buf_out_addr), .buf_out_arm(buf_out_arm),
    .buf_out_q(buf_out_q), .buf_out_len(buf_out_len), .buf_out_hasdata(buf_out_hasdata),
    .buf_out_arm_ack(buf_out_arm_ack),
    .endp_mode(endp_mode), .endp_seq(endp_seq), .endp_halted(endp_halted),
    .ep_in_addr(ep_in_addr), .ep_in_data(ep_in_data), .ep_in_wren(ep_in_wren),
    .ep_in_commit(ep_in_commit), .ep_in_commit_len(ep_in_commit_len),
    .ep_in_ready(ep_in_ready), .ep_in_commit_ack(ep_in_commit_ack),
    .ep_out_addr(ep_out_addr), .ep_out_arm(ep_out_arm),
    .ep_out_q(ep_out_q), .ep_out_len(ep_out_len),
    .ep_out_hasdata(ep_out_hasdata), .ep_out_arm_ack(ep_out_arm_ack),
    .halt_set(halt_set), .halt_clr(halt_clr), .seq_clr(seq_clr),
    .err_undefined(err_undefined), .err_timeout(err_timeout)
  );

  always #5 local_clk = ~local_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending handshake (0 none, 1 commit, 2 arm), its endpoint and age.
  int               m_busy, m_act, m_age;
  logic [LEN_W-1:0] m_len;
  bit [NUM_EP-1:0]  m_halt;
  logic [4:0]       m_seq [NUM_EP];
  bit               m_err_u;

  function automatic logic [1:0] ep_mode(int e);
    return (e == 2 || e == 3) ? 2'd2 : 2'd0;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_act = 0; m_age = 0; m_len = '0; m_halt = '0; m_err_u = 0;
    for (int n = 0; n < NUM_EP; n++) m_seq[n] = 5'd0;
  endtask

  task automatic quiet();
    reset = 0; buf_in_wren = 0; buf_in_commit = 0; buf_out_arm = 0;
    buf_in_addr = '0; buf_in_data = '0; buf_in_commit_len = '0; buf_out_addr = '0;
    ep_in_commit_ack = '0; ep_out_arm_ack = '0; halt_set = '0; halt_clr = '0; seq_clr = '0;
    ep_in_ready = 4'hF; ep_out_hasdata = 4'hF;
    ep_out_q = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    ep_out_len = {11'd300, 11'd200, 11'd100, 11'd50};
  endtask

  // Compare every output with the model, clock once, then advance the model.
  task automatic cyc(string tag);
    int e;
    bit valid, iok, ook, hlt, acc_c, acc_a, ack_i, ack_o, tmo;
    logic [NUM_EP*ADDR_W-1:0] x_iaddr, x_oaddr;
    logic [NUM_EP*DATA_W-1:0] x_idata;
    logic [NUM_EP*LEN_W-1:0]  x_clen;
    logic [NUM_EP-1:0]        x_wren, x_commit, x_arm;
    logic                     x_rdy, x_has;
    logic [DATA_W-1:0]        x_q;
    logic [LEN_W-1:0]         x_len;
    logic [1:0]               x_mode;
    logic [4:0]               x_seq;
    #1;
    e     = (m_busy != 0) ? m_act : int'(sel_endp);
    valid = !reset && e < NUM_EP;
    iok   = valid && (e == 0 || e == 2);
    ook   = valid && (e == 0 || e == 1);
    hlt   = valid && m_halt[e];
    acc_c = m_busy == 0 && buf_in_commit && iok && !hlt;
    acc_a = m_busy == 0 && buf_out_arm && !buf_in_commit && ook && !hlt;
    ack_i = valid && m_busy == 1 && ep_in_commit_ack[m_act];
    ack_o = valid && m_busy == 2 && ep_out_arm_ack[m_act];
    tmo   = !reset && m_busy != 0 && m_age == TC - 1 && !(ack_i || ack_o);
    x_iaddr = '0; x_oaddr = '0; x_idata = '0; x_clen = '0;
    x_wren = '0; x_commit = '0; x_arm = '0;
    x_rdy = 0; x_has = 0; x_q = '0; x_len = '0; x_mode = 2'd0; x_seq = 5'd0;
    if (valid) begin
      if (iok) begin
        x_iaddr[e*ADDR_W +: ADDR_W] = buf_in_addr;
        x_idata[e*DATA_W +: DATA_W] = buf_in_data;
        x_wren[e] = buf_in_wren;
      end
      if (ook) x_oaddr[e*ADDR_W +: ADDR_W] = buf_out_addr;
      x_commit[e] = acc_c;
      x_arm[e]    = acc_a;
      if (acc_c) x_clen[e*LEN_W +: LEN_W] = buf_in_commit_len;
      else if (m_busy == 1) x_clen[e*LEN_W +: LEN_W] = m_len;
      x_rdy  = ep_in_ready[e] && !hlt;
      x_has  = ep_out_hasdata[e] && !hlt;
      x_q    = ep_out_q[e*DATA_W +: DATA_W];
      x_len  = ep_out_len[e*LEN_W +: LEN_W];
      x_mode = ep_mode(e);
      x_seq  = m_seq[e];
    end
    chk({tag, ".ep_in_wren"}, ep_in_wren, x_wren);
    chk({tag, ".ep_in_addr"}, ep_in_addr, x_iaddr);
    chk({tag, ".ep_in_data"}, ep_in_data, x_idata);
    chk({tag, ".ep_in_commit"}, ep_in_commit, x_commit);
    chk({tag, ".ep_in_commit_len"}, ep_in_commit_len, x_clen);
    chk({tag, ".ep_out_addr"}, ep_out_addr, x_oaddr);
    chk({tag, ".ep_out_arm"}, ep_out_arm, x_arm);
    chk({tag, ".buf_in_ready"}, buf_in_ready, x_rdy);
    chk({tag, ".buf_in_commit_ack"}, buf_in_commit_ack, ack_i);
    chk({tag, ".buf_out_q"}, buf_out_q, x_q);
    chk({tag, ".buf_out_len"}, buf_out_len, x_len);
    chk({tag, ".buf_out_hasdata"}, buf_out_hasdata, x_has);
    chk({tag, ".buf_out_arm_ack"}, buf_out_arm_ack, ack_o);
    chk({tag, ".endp_mode"}, endp_mode, x_mode);
    chk({tag, ".endp_seq"}, endp_seq, x_seq);
    chk({tag, ".endp_halted"}, endp_halted, hlt);
    chk({tag, ".err_undefined"}, err_undefined, m_err_u);
    chk({tag, ".err_timeout"}, err_timeout, tmo);
    @(posedge local_clk);
    if (reset) begin
      model_reset();
    end else begin
      m_err_u = (buf_in_wren && !iok) || (m_busy == 0 && buf_in_commit && !iok)
             || (m_busy == 0 && buf_out_arm && !buf_in_commit && !ook);
      for (int n = 0; n < NUM_EP; n++) begin
        if (halt_set[n]) m_halt[n] = 1;
        else if (halt_clr[n]) m_halt[n] = 0;
        if (seq_clr[n]) m_seq[n] = 5'd0;
        else if ((ack_i || ack_o) && n == m_act) m_seq[n] = m_seq[n] + 5'd1;
      end
      if (m_busy != 0) begin
        if (ack_i || ack_o || m_age == TC - 1) m_busy = 0;
        else m_age++;
      end else if (acc_c) begin
        m_busy = 1; m_act = e; m_len = buf_in_commit_len; m_age = 0;
      end else if (acc_a) begin
        m_busy = 2; m_act = e; m_age = 0;
      end
    end
    #1;
  endtask

  initial begin
    quiet();
    model_reset();
    reset = 1;
    sel_endp = 4'd2;
    repeat (2) @(posedge local_clk);
    #1;
    // reset holds every output quiet even with live link inputs
    buf_in_wren = 1; buf_in_addr = 9'd7;
    #1;
    chk("rst.ep_in_wren", ep_in_wren, 4'h0);
    chk("rst.buf_in_ready", buf_in_ready, 1'b0);
    cyc("rst");
    quiet();

    // 1: write routing to ep2
    sel_endp = 4'd2; buf_in_wren = 1; buf_in_addr = 9'd5; buf_in_data = 32'hDEADBEEF;
    #1;
    chk("t1.wren", ep_in_wren, 4'b0100);
    chk("t1.addr2", ep_in_addr[2*ADDR_W +: ADDR_W], 9'd5);
    chk("t1.data2", ep_in_data[2*DATA_W +: DATA_W], 32'hDEADBEEF);
    chk("t1.mode", endp_mode, 2'd2);
    cyc("t1");
    quiet();

    // 2: commit on ep2, ack on third wait cycle, selection moves away meanwhile
    sel_endp = 4'd2; buf_in_commit = 1; buf_in_commit_len = 11'd512;
    #1;
    chk("t2.commit", ep_in_commit, 4'b0100);
    cyc("t2.go");
    buf_in_commit = 0; buf_in_commit_len = 11'd7; sel_endp = 4'd0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) ep_in_commit_ack = 4'b0100;
      #1;
      chk("t2.len_hold", ep_in_commit_len[2*LEN_W +: LEN_W], 11'd512);
      chk("t2.no_repulse", ep_in_commit, 4'b0000);
      chk("t2.ack", buf_in_commit_ack, (k == 2));
      cyc("t2.wait");
    end
    quiet();
    sel_endp = 4'd2;
    #1;
    chk("t2.seq", endp_seq, 5'd1);
    cyc("t2.end");

    // 3: 32 arms on ep1 wrap the sequence number; then clear beats increment
    for (int i = 0; i < 33; i++) begin
      quiet(); sel_endp = 4'd1; buf_out_arm = 1;
      #1;
      if (i == 31) chk("t3.seq31", endp_seq, 5'd31);
      chk("t3.arm", ep_out_arm, 4'b0010);
      cyc("t3.arm");
      quiet(); sel_endp = 4'd1; ep_out_arm_ack = 4'b0010;
      if (i == 32) seq_clr = 4'b0010;
      cyc("t3.ack");
      if (i == 31) begin
        quiet(); sel_endp = 4'd1;
        #1;
        chk("t3.wrap", endp_seq, 5'd0);
      end
    end
    quiet(); sel_endp = 4'd1;
    #1;
    chk("t3.clr", endp_seq, 5'd0);
    cyc("t3.end");

    // 4: timeout on ep0, then ack on the very last cycle
    for (int pass = 0; pass < 2; pass++) begin
      quiet(); sel_endp = 4'd0; buf_in_commit = 1; buf_in_commit_len = 11'd10;
      cyc("t4.go");
      quiet(); sel_endp = 4'd3;
      for (int k = 0; k < TC; k++) begin
        if (pass == 1 && k == TC - 1) ep_in_commit_ack = 4'b0001;
        #1;
        chk("t4.err_timeout", err_timeout, (pass == 0 && k == TC - 1));
        cyc("t4.wait");
      end
      quiet(); sel_endp = 4'd2;
      #1;
      chk("t4.idle_mode", endp_mode, 2'd2);
      cyc("t4.idle");
      sel_endp = 4'd0;
      #1;
      chk("t4.seq0", endp_seq, 5'(pass));
      cyc("t4.seq");
    end

    // 5: illegal direction and out-of-range endpoint
    quiet(); sel_endp = 4'd1; buf_in_commit = 1;
    #1;
    chk("t5.no_commit", ep_in_commit, 4'b0000);
    cyc("t5.c");
    quiet(); sel_endp = 4'd1;
    #1;
    chk("t5.err_c", err_undefined, 1'b1);
    cyc("t5.c1");
    quiet(); sel_endp = 4'd9; buf_out_arm = 1;
    #1;
    chk("t5.err_idle", err_undefined, 1'b0);
    chk("t5.no_arm", ep_out_arm, 4'b0000);
    cyc("t5.a");
    quiet(); sel_endp = 4'd9;
    #1;
    chk("t5.err_a", err_undefined, 1'b1);
    chk("t5.q_inv", buf_out_q, 32'h0);
    cyc("t5.a1");

    // 6: set-beats-clear halt, silent drop, recovery, reset in WAIT_OUT
    quiet(); sel_endp = 4'd2; halt_set = 4'b0100; halt_clr = 4'b0100;
    cyc("t6.halt");
    quiet(); sel_endp = 4'd2; buf_in_commit = 1; buf_in_wren = 1; buf_in_addr = 9'd3;
    #1;
    chk("t6.halted", endp_halted, 1'b1);
    chk("t6.ready", buf_in_ready, 1'b0);
    chk("t6.drop", ep_in_commit, 4'b0000);
    chk("t6.wren", ep_in_wren, 4'b0100);
    cyc("t6.drop");
    quiet(); sel_endp = 4'd2; halt_clr = 4'b0100;
    #1;
    chk("t6.silent", err_undefined, 1'b0);
    cyc("t6.clr");
    quiet(); sel_endp = 4'd2;
    #1;
    chk("t6.unhalted", endp_halted, 1'b0);
    chk("t6.ready1", buf_in_ready, 1'b1);
    cyc("t6.norm");
    quiet(); sel_endp = 4'd0; buf_out_arm = 1;
    cyc("t6.arm");
    quiet(); sel_endp = 4'd0;
    cyc("t6.wait");
    reset = 1; ep_out_arm_ack = 4'b0001;
    #1;
    chk("t6.rst_noack", buf_out_arm_ack, 1'b0);
    cyc("t6.rst");
    for (int n = 0; n < NUM_EP; n++) begin
      quiet(); sel_endp = 4'(n);
      #1;
      chk("t6.seq_rst", endp_seq, 5'd0);
      cyc("t6.post");
    end

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      sel_endp = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      buf_in_wren = ($urandom_range(0, 2) == 0);
      buf_in_addr = 9'($urandom);
      buf_in_data = $urandom;
      buf_in_commit = ($urandom_range(0, 7) == 0);
      buf_in_commit_len = 11'($urandom);
      buf_out_arm = ($urandom_range(0, 7) == 0);
      buf_out_addr = 9'($urandom);
      ep_in_ready = 4'($urandom);
      ep_out_hasdata = 4'($urandom);
      ep_out_q = {$urandom, $urandom, $urandom, $urandom};
      ep_out_len = 44'({$urandom, $urandom});
      ep_in_commit_ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ep_out_arm_ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      halt_set = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
      halt_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      seq_clr = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
